dot_product_engine: RTL and testbench
=====================================

Name: dot_product_engine

Overview:
- Upstream neighbour of the output-memory writer stage.
- Pops paired operands from two input FIFOs (vector A, vector B) and multiply-accumulates VECTOR_LEN element pairs.
- Presents the sum on result_dotProduct and pulses startProcessing_wr for one cycle, so the writer captures the result and advances its write address.

Parameters:
- DATA_WIDTH, 32, width of each FIFO element (unsigned).
- VECTOR_LEN, 8, element pairs per dot product; must be ≥1.
- CNT_WIDTH, $clog2(VECTOR_LEN+1), width of the issue/accumulate counters.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- start  in  1  begin one dot product; sampled only in IDLE.
- fifo_a_empty  in  1  A FIFO empty.
- fifo_a_rdata  in  DATA_WIDTH  A FIFO read data; valid the cycle after fifo_a_rd_en.
- fifo_a_rd_en  out  1  A FIFO pop.
- fifo_b_empty  in  1  B FIFO empty.
- fifo_b_rdata  in  DATA_WIDTH  B FIFO read data; valid the cycle after fifo_b_rd_en.
- fifo_b_rd_en  out  1  B FIFO pop.
- result_dotProduct  out  2*DATA_WIDTH+1  last completed sum.
- startProcessing_wr  out  1  one-cycle result-valid strobe to the writer.
- busy  out  1  high in RUN and DRAIN.

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk.
  - All state resets: FSM to IDLE, counters 0, accumulator 0, pipeline valids 0.
  - result_dotProduct resets to 0; startProcessing_wr resets to 0; busy resets to 0.
  - Reset mid-operation aborts with no strobe. FIFOs are not flushed; the controller owns that.
- FSM: IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE: start=1 -> RUN; accumulator and counters clear on the same edge.
  - RUN: fifo_a_rd_en = fifo_b_rd_en = !fifo_a_empty && !fifo_b_empty && (issue_cnt < VECTOR_LEN). Both outputs are combinational and always equal.
  - RUN: issue_cnt increments on each pop. issue_cnt == VECTOR_LEN -> DRAIN.
  - DRAIN: no pops. The final accumulate -> IDLE.
- Pops are atomic. If either FIFO is empty, neither is popped. There is no partial pop and no error flag; the pipeline stalls.
- Pipeline, for a pop in cycle c:
  - c+1: rdata pair valid; product register loads at the end of c+1 (full 2*DATA_WIDTH-bit unsigned product).
  - c+2: accumulator loads acc + product at the end of c+2.
- Completion: on the edge where the VECTOR_LEN-th product is accumulated:
  - result_dotProduct <= acc + product.
  - startProcessing_wr <= 1 for exactly one cycle.
  - The strobe is visible in cycle c+3 after the final pop.
- Latency: start high in cycle 0 with both FIFOs non-empty -> pops in cycles 1..VECTOR_LEN, strobe in cycle VECTOR_LEN+3.
- result_dotProduct holds its value until the next completion, not just during the strobe.
- Arithmetic: unsigned. The accumulator is 2*DATA_WIDTH+1 bits and wraps modulo 2^(2*DATA_WIDTH+1); there is no saturation.
- start while busy is ignored and not queued. start in the strobe cycle is also ignored, since the FSM is already in IDLE one cycle later.
- Earliest restart: start in the cycle after the strobe.
- Back-to-back vectors: no overlap between consecutive dot products.

Decomposition:
- Shared package dotp_pkg:
  - State enum {IDLE, RUN, DRAIN}.
  - Localparam RESULT_WIDTH = 2*DATA_WIDTH+1.
  - The writer uses the same RESULT_WIDTH.
- Sub-module mac_pipe:
  - Contains the product register, accumulator, valid pipeline and last-flag pipeline.
  - Inputs: in_valid, a, b, clear, last.
  - Outputs: sum, sum_valid.
- The top level holds the FSM, counters and FIFO handshake.

Test Plan:
- Basic dot product (DATA_WIDTH=8, VECTOR_LEN=4): A=[1,2,3,4], B=[5,6,7,8] preloaded, start in cycle 0 -> pops in cycles 1-4, strobe in cycle 7 only, result_dotProduct=70 held afterwards.
- Overflow wrap (DATA_WIDTH=8, VECTOR_LEN=4): all elements 255 -> result = 260100 mod 131072 = 129028.
- Stall: B empty for 3 cycles after the second pop -> no A pop during the stall, result still 70, strobe delayed to cycle 10.
- Start ignored: start re-asserted during RUN and in the strobe cycle -> exactly one strobe, no extra pops, busy falls the cycle after the strobe.
- Reset mid-run: rstn=0 after 2 pops -> the next cycle shows result_dotProduct=0, strobe=0, busy=0, IDLE. A fresh start with new vectors [1,1,1,1]·[2,2,2,2] -> 8.
- Back-to-back with the writer: two vectors giving 70 then 8, start asserted the cycle after each strobe -> the writer captures 70 at wraddr 0 and 8 at wraddr 1.

Source files
------------

// File: rtl/dotp_pkg.sv
// Shared definitions for the dot-product engine and its downstream writer.
//   state_e      : controller state encoding
//   RESULT_WIDTH : result width for the default 32-bit operand build
//   result_width : result width for any operand width (full product + carry)
package dotp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int RESULT_WIDTH       = 2 * DATA_WIDTH_DEFAULT + 1;

    function automatic int result_width(input int data_width);
        return 2 * data_width + 1;
    endfunction

endpackage

// File: rtl/mac_pipe.sv
// Multiply-accumulate pipeline behind the FIFO pop.
//   clk, rstn  : clock, synchronous active-low reset
//   in_valid   : a pop was issued this cycle (operands arrive next cycle)
//   last       : this pop carries the final element pair
//   clear      : zero the accumulator (start of a new vector)
//   a, b       : FIFO read data, valid the cycle after in_valid
//   sum        : last completed sum, held until the next completion
//   sum_valid  : one-cycle strobe when sum updates
module mac_pipe
    import dotp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    input  logic                    last,
    input  logic                    clear,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [2*DATA_WIDTH:0]   sum,
    output logic                    sum_valid
);

    localparam int PW     = 2 * DATA_WIDTH;
    localparam int STAGES = 1;

    // [0]: operands on rdata, [1]: product register holds a valid product
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:0]   last_pipe;
    logic [PW-1:0]     prod;
    logic [PW:0]       acc;
    logic [PW:0]       acc_next;

    // Wraps modulo 2^(PW+1); no saturation.
    assign acc_next = acc + {1'b0, prod};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            prod      <= '0;
            acc       <= '0;
            sum       <= '0;
            sum_valid <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], in_valid};
            last_pipe <= {last_pipe[STAGES-1:0], in_valid & last};
            sum_valid <= vld_pipe[STAGES] & last_pipe[STAGES];
            if (vld_pipe[0])
                prod <= PW'(a) * PW'(b);
            // clear only happens in IDLE, when the pipeline is already empty
            if (clear) begin
                acc <= '0;
            end else if (vld_pipe[STAGES]) begin
                acc <= acc_next;
                if (last_pipe[STAGES])
                    sum <= acc_next;
            end
        end
    end

endmodule

// File: rtl/dot_product_engine.sv
// Dot-product engine: pops paired operands from the A and B FIFOs,
// multiply-accumulates VECTOR_LEN pairs and hands the sum to the writer.
//   clk, rstn           : clock, synchronous active-low reset
//   start               : begin one dot product (sampled in IDLE only)
//   fifo_a_empty/rdata  : A FIFO status and read data (data one cycle after pop)
//   fifo_a_rd_en        : A FIFO pop
//   fifo_b_empty/rdata  : B FIFO status and read data
//   fifo_b_rd_en        : B FIFO pop (always equal to fifo_a_rd_en)
//   result_dotProduct   : last completed sum
//   startProcessing_wr  : one-cycle result-valid strobe to the writer
//   busy                : high in RUN and DRAIN
module dot_product_engine
    import dotp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int VECTOR_LEN = 8,
    parameter int CNT_WIDTH  = $clog2(VECTOR_LEN + 1)
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic                                  fifo_a_empty,
    input  logic [DATA_WIDTH-1:0]                 fifo_a_rdata,
    output logic                                  fifo_a_rd_en,
    input  logic                                  fifo_b_empty,
    input  logic [DATA_WIDTH-1:0]                 fifo_b_rdata,
    output logic                                  fifo_b_rd_en,
    output logic [result_width(DATA_WIDTH)-1:0]   result_dotProduct,
    output logic                                  startProcessing_wr,
    output logic                                  busy
);

    localparam int RES_W = result_width(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LEN      = CNT_WIDTH'(VECTOR_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(VECTOR_LEN - 1);

    state_e               state, state_nx;
    logic [CNT_WIDTH-1:0] issue_cnt;
    logic                 pop;
    logic                 clear;
    logic                 sum_valid;
    logic [RES_W-1:0]     sum;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            issue_cnt <= '0;
        end else begin
            state <= state_nx;
            if (clear)
                issue_cnt <= '0;
            else if (pop)
                issue_cnt <= issue_cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        clear    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    clear    = 1'b1;
                end
            end
            RUN: begin
                // Atomic pop: both FIFOs must have data or neither is touched.
                pop = !fifo_a_empty && !fifo_b_empty && (issue_cnt < LEN);
                if (issue_cnt == LEN)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                // Leave on the strobe cycle so a start during it is ignored.
                if (sum_valid)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    mac_pipe #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (pop),
        .last      (issue_cnt == LAST_IDX),
        .clear     (clear),
        .a         (fifo_a_rdata),
        .b         (fifo_b_rdata),
        .sum       (sum),
        .sum_valid (sum_valid)
    );

    assign fifo_a_rd_en       = pop;
    assign fifo_b_rd_en       = pop;
    assign result_dotProduct  = sum;
    assign startProcessing_wr = sum_valid;
    assign busy               = (state != IDLE);

endmodule

// File: tb/tb_dot_product_engine.sv
module tb_dot_product_engine;

    localparam int DW   = 8;
    localparam int VL   = 4;
    localparam int RW   = 2 * DW + 1;
    localparam int LOGN = 64;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          fifo_a_empty, fifo_b_empty;
    logic [DW-1:0] fifo_a_rdata, fifo_b_rdata;
    logic          fifo_a_rd_en, fifo_b_rd_en;
    logic [RW-1:0] result;
    logic          strobe;
    logic          busy;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [RW-1:0] exp_q[$];
    int            pops[$];
    int            strobes[$];
    logic [RW-1:0] res_log[LOGN];
    logic          stb_log[LOGN];
    logic          busy_log[LOGN];
    logic [RW-1:0] wr_mem[4];
    int            wraddr;
    bit            force_b;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    dot_product_engine #(
        .DATA_WIDTH (DW),
        .VECTOR_LEN (VL)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .start              (start),
        .fifo_a_empty       (fifo_a_empty),
        .fifo_a_rdata       (fifo_a_rdata),
        .fifo_a_rd_en       (fifo_a_rd_en),
        .fifo_b_empty       (fifo_b_empty),
        .fifo_b_rdata       (fifo_b_rdata),
        .fifo_b_rd_en       (fifo_b_rd_en),
        .result_dotProduct  (result),
        .startProcessing_wr (strobe),
        .busy               (busy)
    );

    // FIFO models: read data appears the cycle after the pop.
    always @(posedge clk) begin
        if (fifo_a_rd_en && qa.size() > 0) fifo_a_rdata <= qa.pop_front();
        if (fifo_b_rd_en && qb.size() > 0) fifo_b_rdata <= qb.pop_front();
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic set_empties();
        fifo_a_empty = (qa.size() == 0);
        fifo_b_empty = (qb.size() == 0) || force_b;
    endtask

    // Sample cycle k at the falling edge, then move to the next cycle.
    task automatic step(input int k);
        @(negedge clk);
        chk("rd_en_pair", fifo_a_rd_en, fifo_b_rd_en);
        if (fifo_a_rd_en) pops.push_back(k);
        if (k < LOGN) begin
            res_log[k]  = result;
            stb_log[k]  = strobe;
            busy_log[k] = busy;
        end
        if (strobe) begin
            strobes.push_back(k);
            chk("strobe_expected", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("sb_result", result, exp_q.pop_front());
            wr_mem[wraddr % 4] = result;
            wraddr++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec(input logic [DW-1:0] a[VL], input logic [DW-1:0] b[VL], input bit expect_it);
        logic [RW-1:0] acc;
        acc = '0;
        for (int i = 0; i < VL; i++) begin
            qa.push_back(a[i]);
            qb.push_back(b[i]);
            acc = acc + RW'(a[i]) * RW'(b[i]);
        end
        if (expect_it) exp_q.push_back(acc);
    endtask

    task automatic run_vec(input int n, input int s1, input int s2, input int st_lo, input int st_hi);
        pops.delete();
        strobes.delete();
        for (int k = 0; k < n; k++) begin
            start   = (k == 0) || (k == s1) || (k == s2);
            force_b = (k >= st_lo) && (k <= st_hi);
            set_empties();
            step(k);
        end
        start   = 1'b0;
        force_b = 1'b0;
    endtask

    initial begin
        rstn    = 1'b0;
        start   = 1'b0;
        force_b = 1'b0;
        wraddr  = 0;
        set_empties();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_strobe", strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", fifo_a_rd_en, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Basic: 1*5+2*6+3*7+4*8 = 70
        load_vec('{1, 2, 3, 4}, '{5, 6, 7, 8}, 1);
        run_vec(12, -1, -1, -1, -1);
        chk("basic_pop_count", pops.size(), 4);
        chk("basic_first_pop", at(pops, 0), 1);
        chk("basic_last_pop", at(pops, 3), 4);
        chk("basic_strobe_count", strobes.size(), 1);
        chk("basic_strobe_cycle", at(strobes, 0), 7);
        chk("basic_strobe_one_cycle", stb_log[8], 0);
        chk("basic_result_held", res_log[11], 70);
        chk("basic_busy_in_strobe", busy_log[7], 1);
        chk("basic_busy_after", busy_log[8], 0);

        // Overflow: 4*255*255 = 260100 wraps to 129028
        load_vec('{255, 255, 255, 255}, '{255, 255, 255, 255}, 1);
        run_vec(12, -1, -1, -1, -1);
        chk("wrap_strobe_cycle", at(strobes, 0), 7);
        chk("wrap_result", res_log[11], 129028);

        // Stall: B empty during cycles 3..5
        load_vec('{1, 2, 3, 4}, '{5, 6, 7, 8}, 1);
        run_vec(14, -1, -1, 3, 5);
        chk("stall_pop_count", pops.size(), 4);
        chk("stall_second_pop", at(pops, 1), 2);
        chk("stall_resume_pop", at(pops, 2), 6);
        chk("stall_strobe_cycle", at(strobes, 0), 10);
        chk("stall_result", res_log[13], 70);

        // Start during RUN (cycle 2) and in the strobe cycle (7) is ignored
        load_vec('{1, 2, 3, 4}, '{5, 6, 7, 8}, 1);
        load_vec('{9, 9, 9, 9}, '{9, 9, 9, 9}, 0);
        run_vec(16, 2, 7, -1, -1);
        chk("ign_strobe_count", strobes.size(), 1);
        chk("ign_strobe_cycle", at(strobes, 0), 7);
        chk("ign_pop_count", pops.size(), 4);
        chk("ign_fifo_left", qa.size(), 4);
        chk("ign_busy_in_strobe", busy_log[7], 1);
        chk("ign_busy_after", busy_log[8], 0);
        qa.delete();
        qb.delete();

        // Reset mid-run after two pops
        load_vec('{1, 2, 3, 4}, '{5, 6, 7, 8}, 0);
        pops.delete();
        strobes.delete();
        for (int k = 0; k < 10; k++) begin
            start = (k == 0);
            rstn  = (k != 3);
            set_empties();
            step(k);
        end
        rstn  = 1'b1;
        start = 1'b0;
        chk("rstmid_busy_before", busy_log[2], 1);
        chk("rstmid_result_before", res_log[3], 70);
        chk("rstmid_result", res_log[4], 0);
        chk("rstmid_strobe", stb_log[4], 0);
        chk("rstmid_busy", busy_log[4], 0);
        chk("rstmid_no_strobe", strobes.size(), 0);
        qa.delete();
        qb.delete();
        load_vec('{1, 1, 1, 1}, '{2, 2, 2, 2}, 1);
        run_vec(12, -1, -1, -1, -1);
        chk("rstmid_fresh_strobe", at(strobes, 0), 7);
        chk("rstmid_fresh_result", res_log[11], 8);

        // Back-to-back into the writer: restart the cycle after each strobe
        wraddr = 0;
        load_vec('{1, 2, 3, 4}, '{5, 6, 7, 8}, 1);
        load_vec('{1, 1, 1, 1}, '{2, 2, 2, 2}, 1);
        run_vec(20, 8, -1, -1, -1);
        chk("b2b_strobe0", at(strobes, 0), 7);
        chk("b2b_strobe1", at(strobes, 1), 15);
        chk("b2b_wr0", wr_mem[0], 70);
        chk("b2b_wr1", wr_mem[1], 8);
        chk("b2b_wraddr", wraddr, 2);
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
